ifetch_ctrl: RTL and testbench

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

---
 rtl/ifetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ifetch_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: PC sequencer, 2-entry {pc, word} buffer and IDLE/RUN/STOP control.
// Optional end-of-program stop is enabled by defining IFETCH_END_STOP_EN.
module ifetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] END_ADDR = 32'h0000_0138
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [1:0][31:0]  mem_pc_q, mem_pc_d;
   logic [1:0][31:0]  mem_data_q, mem_data_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;

   logic              push_s;
   logic              pop_s;
   logic              flush_s;
   logic              can_push_s;
   logic              end_hit_s;
   logic              unused_s;

   assign pop_s      = (count_q != 2'd0) && inst_ready;
   assign can_push_s = (count_q != 2'd2) || pop_s;
   assign end_hit_s  = (fetch_pc_q == END_ADDR);

   assign rom_addr   = fetch_pc_q;
   assign inst_valid = (count_q != 2'd0);
   assign inst_pc    = mem_pc_q[rd_ptr_q];
   assign inst_data  = mem_data_q[rd_ptr_q];

`ifdef IFETCH_END_STOP_EN
   logic done_q, done_d;
   assign done      = done_q;
   assign done_d    = (state_d == ST_STOP);
   assign unused_s  = ^redirect_pc[1:0];
`else
   assign done      = 1'b0;
   assign unused_s  = ^{redirect_pc[1:0], end_hit_s};
`endif

   // Control FSM and fetch PC; a redirect overrides any push for this cycle.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      push_s     = 1'b0;
      flush_s    = 1'b0;
      if (redirect_valid) begin
         flush_s    = 1'b1;
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         if (state_q == ST_IDLE) begin
            state_d = ST_IDLE;
         end else begin
            state_d = ST_RUN;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fetch_en) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (!fetch_en) begin
                  state_d = ST_IDLE;
               end else if (can_push_s) begin
                  push_s     = 1'b1;
                  fetch_pc_d = fetch_pc_q + 32'd4;
`ifdef IFETCH_END_STOP_EN
                  if (end_hit_s) begin
                     state_d = ST_STOP;
                  end else begin
                     state_d = ST_RUN;
                  end
`endif
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_STOP: state_d = ST_STOP;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Two-entry buffer: write at wr_ptr, read at rd_ptr, count tracks occupancy.
   always_comb begin
      mem_pc_d   = mem_pc_q;
      mem_data_d = mem_data_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (flush_s) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_s) begin
            mem_pc_d[wr_ptr_q]   = fetch_pc_q;
            mem_data_d[wr_ptr_q] = rom_data;
            wr_ptr_d             = ~wr_ptr_q;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         mem_pc_q   <= '0;
         mem_data_q <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_pc_q   <= mem_pc_d;
         mem_data_q <= mem_data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

`ifdef IFETCH_END_STOP_EN
   // Done flag follows entry into STOP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed self-checking bench for ifetch_ctrl with an XOR-pattern ROM model.
module tb_ifetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        done;

   int tests_run    = 0;
   int tests_failed = 0;

   ifetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
      .done           (done)
   );

   assign rom_data = rom_addr ^ 32'hA5A5_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag, input int max_cycles);
      int n = 0;
      while (!inst_valid && n < max_cycles) begin
         step();
         n++;
      end
      check_eq(tag, {31'd0, inst_valid}, 32'd1);
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc);
      check_eq({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
      check_eq({tag, "_pc"}, inst_pc, pc);
      check_eq({tag, "_data"}, inst_data, pc ^ 32'hA5A5_0000);
   endtask

   initial begin
      rst_n          = 1'b0;
      fetch_en       = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      #3;
      check_eq("rst_valid", {31'd0, inst_valid}, 32'd0);
      check_eq("rst_pc", inst_pc, 32'd0);
      check_eq("rst_data", inst_data, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_addr", rom_addr, 32'd0);

      // Streaming start
      @(negedge clk);
      rst_n      = 1'b1;
      fetch_en   = 1'b1;
      inst_ready = 1'b1;
      wait_valid("start_wait", 5);
      check_head("stream0", 32'h0000_0000);
      step();
      check_head("stream1", 32'h0000_0004);
      step();
      check_head("stream2", 32'h0000_0008);

      // Backpressure: head 8 held, 12 buffered, fetch waits at 16
      inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_head("stall_head", 32'h0000_0008);
         check_eq("stall_addr", rom_addr, 32'h0000_0010);
      end
      inst_ready = 1'b1;
      step();
      check_head("rel0", 32'h0000_000C);
      check_eq("rel0_addr", rom_addr, 32'h0000_0014);
      step();
      check_head("rel1", 32'h0000_0010);
      check_eq("rel1_addr", rom_addr, 32'h0000_0018);
      step();
      check_head("rel2", 32'h0000_0014);

      // Redirect with a full buffer
      inst_ready = 1'b0;
      step();
      step();
      check_eq("full_valid", {31'd0, inst_valid}, 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0066;
      step();
      check_eq("redir_valid", {31'd0, inst_valid}, 32'd0);
      check_eq("redir_addr", rom_addr, 32'h0000_0064);
      redirect_valid = 1'b0;
      inst_ready     = 1'b1;
      step();
      check_head("redir_head", 32'h0000_0064);

      // Address wrap
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      step();
      check_eq("wrap_flush", {31'd0, inst_valid}, 32'd0);
      redirect_valid = 1'b0;
      step();
      check_head("wrap0", 32'hFFFF_FFF8);
      step();
      check_head("wrap1", 32'hFFFF_FFFC);
      step();
      check_head("wrap2", 32'h0000_0000);

      // Program end address
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0130;
      step();
      redirect_valid = 1'b0;
      step();
      check_head("end0", 32'h0000_0130);
      step();
      check_head("end1", 32'h0000_0134);
      check_eq("end1_done", {31'd0, done}, 32'd0);
      step();
      check_head("end2", 32'h0000_0138);
`ifdef IFETCH_END_STOP_EN
      check_eq("stop_done", {31'd0, done}, 32'd1);
      step();
      check_eq("stop_valid", {31'd0, inst_valid}, 32'd0);
      check_eq("stop_addr", rom_addr, 32'h0000_013C);
      check_eq("stop_done2", {31'd0, done}, 32'd1);
      step();
      check_eq("stop_hold", rom_addr, 32'h0000_013C);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0000;
      step();
      redirect_valid = 1'b0;
      check_eq("resume_done", {31'd0, done}, 32'd0);
      step();
      check_head("resume0", 32'h0000_0000);
`else
      step();
      check_head("past_end", 32'h0000_013C);
      check_eq("no_done", {31'd0, done}, 32'd0);
`endif

      // fetch_en low: buffered entries still drain
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      step();
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      step();
      step();
      step();
      check_head("fill_head", 32'h0000_0200);
      check_eq("fill_addr", rom_addr, 32'h0000_0208);
      fetch_en = 1'b0;
      step();
      check_head("idle_head", 32'h0000_0200);
      inst_ready = 1'b1;
      step();
      check_head("drain0", 32'h0000_0204);
      step();
      check_eq("drain_empty", {31'd0, inst_valid}, 32'd0);
      check_eq("drain_addr", rom_addr, 32'h0000_0208);

      // Asynchronous reset mid-stream with two buffered entries
      fetch_en   = 1'b1;
      inst_ready = 1'b0;
      step();
      step();
      step();
      check_head("pre_rst", 32'h0000_0208);
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid", {31'd0, inst_valid}, 32'd0);
      check_eq("arst_addr", rom_addr, 32'd0);
      check_eq("arst_pc", inst_pc, 32'd0);
      @(negedge clk);
      rst_n      = 1'b1;
      inst_ready = 1'b1;
      wait_valid("restart_wait", 5);
      check_head("restart", 32'h0000_0000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
